// File: rtl/systolic_drain_right_out.sv
// systolic_drain_right_out
//   Output-side deskew stage for the MAC array. Column c of the array's bottom
//   row emits its results c beats later than column 0. This block gathers
//   2*MAC_WIDTH-1 beats into a full MAC_WIDTH x MAC_WIDTH result matrix. It
//   holds that matrix until the consumer acknowledges it, then re-arms.
//
//   Optional feature: define DRAIN_OVERRUN_DETECT_EN to build the sticky
//   overrun flag. It is set by lane_valid outside COLLECT, or by start while
//   busy. When the macro is undefined, overrun is tied to 0.
module systolic_drain_right_out #(
  parameter int DATA_SIZE = 16,
  parameter int MAC_WIDTH = 8,
  parameter int BEAT_W    = 5
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [DATA_SIZE*MAC_WIDTH-1:0]           lane_in,
  input  logic                                     lane_valid,
  output logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] matrix_out,
  output logic                                     matrix_out_valid,
  input  logic                                     matrix_out_ack,
  output logic                                     busy,
  output logic                                     overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * MAC_WIDTH - 2);

  state_t               state;
  state_t               state_next;
  logic [BEAT_W-1:0]    beat;
  logic                 capture;
  logic [DATA_SIZE-1:0] buffer [MAC_WIDTH][MAC_WIDTH];

  // A beat is consumed only while collecting. Bubbles (lane_valid=0) do not advance anything.
  assign capture = (state == COLLECT) && lane_valid;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments, so every
  // always_ff block reads the values from before the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: start arms collection, the last beat freezes the matrix, and ack releases it.
  // NOTE: the default assignment at the top of the block keeps every path
  // assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (capture && (beat == LAST_BEAT)) state_next = HOLD;
      HOLD:    if (matrix_out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat counter: cleared when a tile is armed and advanced on each captured beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat <= '0;
    end else if ((state == IDLE) && start) begin
      beat <= '0;
    end else if (capture) begin
      beat <= beat + 1'b1;
    end
  end

  // Deskew buffer: at beat k, lane c carries element (k-c, c). So element (r,c) is written at beat r+c.
  // NOTE: this storage is reset explicitly because matrix_out must read as all
  // zeros after reset. Between tiles it is never cleared, because each
  // element is overwritten exactly once per tile.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < MAC_WIDTH; r++) begin
        for (int c = 0; c < MAC_WIDTH; c++) begin
          buffer[r][c] <= '0;
        end
      end
    end else if (capture) begin
      for (int r = 0; r < MAC_WIDTH; r++) begin
        for (int c = 0; c < MAC_WIDTH; c++) begin
          if (beat == BEAT_W'(r + c)) begin
            buffer[r][c] <= lane_in[c*DATA_SIZE +: DATA_SIZE];
          end
        end
      end
    end
  end

  // Flatten the buffer into the row-major output bus.
  for (genvar r = 0; r < MAC_WIDTH; r++) begin : g_row
    for (genvar c = 0; c < MAC_WIDTH; c++) begin : g_col
      assign matrix_out[(r*MAC_WIDTH + c)*DATA_SIZE +: DATA_SIZE] = buffer[r][c];
    end
  end

  assign matrix_out_valid = (state == HOLD);
  assign busy             = (state != IDLE);

`ifdef DRAIN_OVERRUN_DETECT_EN
  logic overrun_q;

  // Sticky protocol-error flag. It is set by data outside COLLECT, or by start while busy. Only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if ((lane_valid && (state != COLLECT)) || (start && (state != IDLE))) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_drain_right_out.sv
// tb_systolic_drain_right_out
//   Directed bench with a scoreboard. Each tile sent pushes its expected matrix
//   into a queue. A monitor pops that matrix and compares it when
//   matrix_out_valid rises. Control outputs are checked inline.
module tb_systolic_drain_right_out;

  localparam int DS    = 16;
  localparam int MW    = 8;
  localparam int BW    = 5;
  localparam int NB    = 2 * MW - 1;
  localparam int MAT_W = DS * MW * MW;

`ifdef DRAIN_OVERRUN_DETECT_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  typedef logic [MAT_W-1:0]   mat_t;
  typedef logic [DS*MW-1:0]   lane_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  logic  start = 1'b0;
  lane_t lane_in = '0;
  logic  lane_valid = 1'b0;
  mat_t  matrix_out;
  logic  matrix_out_valid;
  logic  matrix_out_ack = 1'b0;
  logic  busy;
  logic  overrun;

  systolic_drain_right_out #(
    .DATA_SIZE(DS),
    .MAC_WIDTH(MW),
    .BEAT_W   (BW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .lane_in         (lane_in),
    .lane_valid      (lane_valid),
    .matrix_out      (matrix_out),
    .matrix_out_valid(matrix_out_valid),
    .matrix_out_ack  (matrix_out_ack),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  mat_t exp_q[$];
  int   tiles_seen = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic mat_t make_mat(input int base);
    mat_t m;
    for (int r = 0; r < MW; r++)
      for (int c = 0; c < MW; c++)
        m[(r*MW + c)*DS +: DS] = DS'(r*MW + c + 1 + base);
    return m;
  endfunction

  // Lane c at beat k carries element (k-c, c) inside its window. Outside the window it carries 0xFFFF.
  function automatic lane_t beat_data(input int k, input int base);
    lane_t v;
    for (int c = 0; c < MW; c++) begin
      if (k >= c && k <= c + MW - 1) v[c*DS +: DS] = DS'((k - c)*MW + c + 1 + base);
      else                           v[c*DS +: DS] = 16'hFFFF;
    end
    return v;
  endfunction

  // Monitor: compare the matrix against the scoreboard on every rising edge of matrix_out_valid.
  always @(negedge clock) begin
    mat_t e;
    if (matrix_out_valid && !prev_valid) begin
      rise_cyc = cyc;
      tiles_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tile: valid rose at cycle %0d with no tile expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (matrix_out !== e) begin
          errors++;
          for (int i = 0; i < MW*MW; i++) begin
            if (matrix_out[i*DS +: DS] !== e[i*DS +: DS]) begin
              $display("FAIL tile_%0d_matrix: element (%0d,%0d) got 0x%0h, expected 0x%0h",
                       tiles_seen, i / MW, i % MW, matrix_out[i*DS +: DS], e[i*DS +: DS]);
              break;
            end
          end
        end
      end
    end
    prev_valid = matrix_out_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    lane_valid     = 1'b0;
    lane_in        = '0;
    matrix_out_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_beats(input int base, input bit bubbles, input int count, output int last_cyc);
    for (int k = 0; k < count; k++) begin
      if (bubbles && k > 0) begin
        lane_valid = 1'b0;
        lane_in    = '1;
        tick();
      end
      lane_valid = 1'b1;
      lane_in    = beat_data(k, base);
      tick();
      last_cyc = cyc;
    end
    lane_valid = 1'b0;
    lane_in    = '0;
  endtask

  task automatic run_tile(input int base, input bit bubbles, output int start_cyc, output int last_cyc);
    exp_q.push_back(make_mat(base));
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beats(base, bubbles, NB, last_cyc);
  endtask

  task automatic wait_tile(input int want, input string name);
    for (int i = 0; i < 40; i++) begin
      if (tiles_seen >= want) break;
      tick();
    end
    check(name, 64'(tiles_seen), 64'(want));
  endtask

  task automatic ack_pulse(input string name);
    matrix_out_ack = 1'b1;
    tick();
    matrix_out_ack = 1'b0;
    check({name, "_valid_low"}, 64'(matrix_out_valid), 64'd0);
    check({name, "_busy_low"},  64'(busy),             64'd0);
  endtask

  initial begin
    int s_cyc, l_cyc, seen;
    bit stable;

    // Reset state.
    do_reset();
    check("reset_valid",   64'(matrix_out_valid), 64'd0);
    check("reset_busy",    64'(busy),             64'd0);
    check("reset_overrun", 64'(overrun),          64'd0);
    check("reset_matrix_zero", 64'(matrix_out == '0), 64'd1);

    // 1: basic tile with back-to-back beats.
    run_tile(0, 1'b0, s_cyc, l_cyc);
    wait_tile(1, "t1_tile_seen");
    check("t1_latency", 64'(rise_cyc - s_cyc), 64'd16);
    check("t1_busy_in_hold", 64'(busy), 64'd1);
    ack_pulse("t1_ack");

    // 2: bubbles on alternate cycles.
    run_tile(0, 1'b1, s_cyc, l_cyc);
    wait_tile(2, "t2_tile_seen");
    check("t2_valid_after_last_beat", 64'(rise_cyc), 64'(l_cyc));

    // 3: hold the matrix for 10 cycles while noise sits on the lanes, then ack.
    stable = 1'b1;
    lane_valid = 1'b1;
    lane_in    = {MW{16'hAAAA}};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (matrix_out !== make_mat(0) || matrix_out_valid !== 1'b1) stable = 1'b0;
    end
    lane_valid = 1'b0;
    lane_in    = '0;
    check("t3_hold_stable", 64'(stable), 64'd1);
    ack_pulse("t3_ack");
    run_tile(100, 1'b0, s_cyc, l_cyc);
    wait_tile(3, "t3_second_tile_seen");
    ack_pulse("t3_ack2");

    // 4: asynchronous reset after beat 6 of a tile.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beats(900, 1'b0, 7, l_cyc);
    #2 reset = 1'b1;
    #1;
    check("t4_reset_valid",   64'(matrix_out_valid), 64'd0);
    check("t4_reset_busy",    64'(busy),             64'd0);
    check("t4_reset_overrun", 64'(overrun),          64'd0);
    check("t4_reset_matrix_zero", 64'(matrix_out == '0), 64'd1);
    #1 reset = 1'b0;
    tick();
    run_tile(7, 1'b0, s_cyc, l_cyc);
    wait_tile(4, "t4_fresh_tile_seen");
    ack_pulse("t4_ack");

    // 5: start and ack in the same HOLD cycle. Only the ack takes effect.
    run_tile(20, 1'b0, s_cyc, l_cyc);
    wait_tile(5, "t5_tile_seen");
    matrix_out_ack = 1'b1;
    start          = 1'b1;
    tick();
    matrix_out_ack = 1'b0;
    start          = 1'b0;
    check("t5_busy_low",  64'(busy),             64'd0);
    check("t5_valid_low", 64'(matrix_out_valid), 64'd0);
    seen = tiles_seen;
    send_beats(300, 1'b0, NB, l_cyc);
    tick();
    tick();
    check("t5_no_tile_from_stray_beats", 64'(tiles_seen), 64'(seen));
    check("t5_still_idle", 64'(busy), 64'd0);
    check("t5_matrix_kept", 64'(matrix_out == make_mat(20)), 64'd1);
    run_tile(40, 1'b0, s_cyc, l_cyc);
    wait_tile(6, "t5_next_tile_seen");
    ack_pulse("t5_ack");

    // 6: overrun from lane_valid in IDLE. The flag is sticky until reset.
    do_reset();
    check("t6_overrun_cleared", 64'(overrun), 64'd0);
    lane_valid = 1'b1;
    lane_in    = {MW{16'h1234}};
    tick();
    tick();
    lane_valid = 1'b0;
    lane_in    = '0;
    check("t6_overrun_set", 64'(overrun), 64'(OVR_EXP));
    run_tile(60, 1'b0, s_cyc, l_cyc);
    wait_tile(7, "t6_tile_seen");
    check("t6_overrun_sticky", 64'(overrun), 64'(OVR_EXP));
    ack_pulse("t6_ack");
    do_reset();
    check("t6_overrun_reset", 64'(overrun), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_drain_right_out.md
Name: systolic_drain_right_out

Overview:
- Output-side counterpart of the left-edge skew/setup stage.
- The MAC array emits result elements from its bottom edge with the same diagonal skew that the setup stage applies on entry: column c is delayed c beats.
- This block deskews those staggered beats into a full MAC_WIDTH x MAC_WIDTH result matrix.
- It holds the matrix until the downstream consumer acknowledges it, then re-arms for the next tile.

Parameters:
- DATA_SIZE, 16: width of one result element in bits (accumulator width).
- MAC_WIDTH, 8: array dimension; matrix is MAC_WIDTH x MAC_WIDTH.
- BEAT_W, 5: width of the beat counter; must hold 2*MAC_WIDTH-2.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that arms collection of one tile.
- lane_in, input, DATA_SIZE*MAC_WIDTH: bottom-row array outputs; lane c is at [c*DATA_SIZE +: DATA_SIZE].
- lane_valid, input, 1: lane_in carries a beat this cycle.
- matrix_out, output, DATA_SIZE*MAC_WIDTH*MAC_WIDTH: element (r,c) is at [(r*MAC_WIDTH+c)*DATA_SIZE +: DATA_SIZE].
- matrix_out_valid, output, 1: matrix_out is complete and stable.
- matrix_out_ack, input, 1: consumer has taken the matrix.
- busy, output, 1: high in COLLECT or HOLD.
- overrun, output, 1: sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state, including mid-collection): state=IDLE, beat=0, every matrix_out element=0, matrix_out_valid=0, busy=0, overrun=0.

- States:
  - IDLE: start=1 -> COLLECT with beat=0, busy=1 from the next cycle. lane_valid is ignored.
  - COLLECT: each cycle with lane_valid=1 is beat k (k = current beat count).
    - For every lane c with c <= k <= c+MAC_WIDTH-1, write lane_in[c] to element (k-c, c).
    - Lanes outside that window are not written that beat.
    - beat increments. Cycles with lane_valid=0 do nothing (gaps/bubbles are allowed).
    - When k = 2*MAC_WIDTH-2 is captured -> HOLD. matrix_out_valid rises on that same edge, so it is visible in the cycle after the last beat.
  - HOLD: matrix_out_valid=1 and matrix_out is frozen. lane_valid and start are ignored.
    - matrix_out_ack=1 -> IDLE on that edge: matrix_out_valid=0 and busy=0 next cycle.
    - matrix_out keeps its last values after leaving HOLD.
- start while busy is ignored.
- ack outside HOLD is ignored.
- start and ack asserted in the same HOLD cycle: go to IDLE only; the start is dropped.
- Beats per tile: exactly 2*MAC_WIDTH-1. Every element is written exactly once per tile, so the buffer is not cleared between tiles.
- Latency: minimum start-to-valid is 1 + (2*MAC_WIDTH-1) cycles with back-to-back beats (16 cycles for MAC_WIDTH=8).

Optional Feature:
- Macro: DRAIN_OVERRUN_DETECT_EN.
- Defined: overrun is set, and stays set until reset, when any of these occur:
  - lane_valid=1 in IDLE;
  - lane_valid=1 in HOLD;
  - start=1 while busy.
  The data is still ignored exactly as in normal operation.
- Undefined: overrun is tied to 0 and no detection logic is built.

Test Plan:
1. Basic tile (MAC_WIDTH=8).
   - Stimulus: reset; start; then 15 back-to-back beats where lane c at beat k carries (k-c)*8+c+1 when in window, else 0xFFFF.
   - Required: matrix_out_valid high 16 cycles after start; element (r,c) = r*8+c+1 (element (7,7)=64); no element equals 0xFFFF.
2. Bubbles.
   - Stimulus: same data as test 1, with lane_valid low on alternate cycles.
   - Required: identical matrix; valid rises the cycle after the 15th valid beat.
3. Hold/ack.
   - Stimulus: keep ack low 10 cycles, driving lane_valid with 0xAAAA; then pulse ack.
   - Required: matrix unchanged while held; valid=0 and busy=0 one cycle after ack; second tile of values +100 is collected correctly.
4. Reset mid-operation.
   - Stimulus: assert reset asynchronously after beat 6.
   - Required: all outputs 0 immediately; a fresh start collects a full tile correctly.
5. Start and ack in the same HOLD cycle.
   - Required: IDLE, busy=0; lane beats before the next start are ignored.
6. Overrun (macro defined).
   - Stimulus: lane_valid in IDLE.
   - Required: overrun=1 and stays 1 through a subsequent good tile until reset.
   - With macro undefined: overrun stays 0.
